// File: rtl/inv_shift_rows_serial.sv
// inv_shift_rows_serial
// Byte-serial AES InvShiftRows with two ping-pong 16-byte banks.
// One bank fills in input order while the other drains in permuted order,
// so the block sustains one byte per cycle in each direction.
// Optional build macro: INV_SR_PAR_OUT_EN adds par_valid/par_state, a
// parallel view of the permuted block currently being drained.
module inv_shift_rows_serial (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [7:0]   in_byte,
    output logic         in_ready,
    output logic         out_valid,
    output logic [7:0]   out_byte,
    output logic         out_last,
    input  logic         out_ready
`ifdef INV_SR_PAR_OUT_EN
    ,
    output logic         par_valid,
    output logic [127:0] par_state
`endif
);

    // Two banks of 16 bytes, stored in arrival (input index) order.
    logic [7:0] bank_mem [0:1][0:15];

    logic [1:0] full_reg;
    logic [1:0] full_next;
    logic       wr_bank_reg;
    logic       wr_bank_next;
    logic       rd_bank_reg;
    logic       rd_bank_next;
    logic [3:0] load_count_reg;
    logic [3:0] load_count_next;
    logic [3:0] drain_count_reg;
    logic [3:0] drain_count_next;

    logic       in_fire;
    logic       out_fire;
    logic       load_done;
    logic       drain_done;
    logic [3:0] rd_idx;

    // Handshakes derive only from the full flags, never from the opposite
    // side's handshake, so there is no combinational path input->output.
    assign in_ready   = !full_reg[wr_bank_reg];
    assign out_valid  = full_reg[rd_bank_reg];
    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign load_done  = in_fire && (load_count_reg == 4'd15);
    assign drain_done = out_fire && (drain_count_reg == 4'd15);

    // Output position j takes input byte (13*j) mod 16; the 4-bit product
    // truncates, which is exactly the mod 16.
    assign rd_idx   = drain_count_reg * 4'd13;
    assign out_byte = bank_mem[rd_bank_reg][rd_idx];
    assign out_last = out_valid && (drain_count_reg == 4'd15);

    // Next-state for flags, bank pointers and counters.
    always_comb begin
        full_next        = full_reg;
        wr_bank_next     = wr_bank_reg;
        rd_bank_next     = rd_bank_reg;
        load_count_next  = load_count_reg;
        drain_count_next = drain_count_reg;

        if (in_fire) begin
            load_count_next = load_count_reg + 4'd1;
        end
        if (load_done) begin
            full_next[wr_bank_reg] = 1'b1;
            wr_bank_next           = !wr_bank_reg;
        end

        if (out_fire) begin
            drain_count_next = drain_count_reg + 4'd1;
        end
        // A load can only complete into an empty bank and a drain only
        // from a full one, so the two updates always hit different bits.
        if (drain_done) begin
            full_next[rd_bank_reg] = 1'b0;
            rd_bank_next           = !rd_bank_reg;
        end
    end

    // Control state register; reset wins over any concurrent transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg        <= 2'b00;
            wr_bank_reg     <= 1'b0;
            rd_bank_reg     <= 1'b0;
            load_count_reg  <= 4'd0;
            drain_count_reg <= 4'd0;
        end else begin
            full_reg        <= full_next;
            wr_bank_reg     <= wr_bank_next;
            rd_bank_reg     <= rd_bank_next;
            load_count_reg  <= load_count_next;
            drain_count_reg <= drain_count_next;
        end
    end

    // Data storage: written in input order, never cleared (flags gate use).
    always_ff @(posedge clk) begin
        if (in_fire && !rst) begin
            bank_mem[wr_bank_reg][load_count_reg] <= in_byte;
        end
    end

`ifdef INV_SR_PAR_OUT_EN
    assign par_valid = out_valid;

    // Parallel permuted view of the read bank; MSB byte is output byte 0.
    for (genvar gi = 0; gi < 16; gi++) begin : g_par
        localparam int SRC = (13 * gi) % 16;
        assign par_state[127 - 8*gi -: 8] = bank_mem[rd_bank_reg][4'(SRC)];
    end
`endif

endmodule
